rect_fill_engine: RTL and testbench
===================================

# rect_fill_engine

Drawing engine that sits directly upstream of the VGA framebuffer stage: accepts one rectangle command (origin, size, colour), clips it to the 160x120 framebuffer and streams one pixel write per clock on the framebuffer's Enable_Draw/Draw_X/Draw_Y/Draw_Color write port. Used by the processor for clear-screen, filled boxes and (optionally) outlined boxes without per-pixel store instructions.

## Interface
- FB_WIDTH, 160, framebuffer width in pixels
- FB_HEIGHT, 120, framebuffer height in pixels
- COLOR_BITS, 9, colour width (RGB 3:3:3)

- Fast_Clock  in  1  single clock (same as framebuffer write clock)
- Reset_N  in  1  reset, asynchronous, active-low
- Cmd_Valid  in  1  command present
- Cmd_Ready  out  1  engine idle, command accepted when Cmd_Valid & Cmd_Ready at rising edge
- Cmd_X  in  8  left column (unsigned)
- Cmd_Y  in  7  top row (unsigned)
- Cmd_W  in  8  width in pixels
- Cmd_H  in  8  height in pixels
- Cmd_Color  in  COLOR_BITS  fill colour
- Cmd_Outline  in  1  outline-only request (see Configuration)
- Hold  in  1  freeze pixel stream (write port shared with processor)
- Enable_Draw  out  1  pixel write strobe
- Draw_X, Draw_Y  out  32 each  pixel coordinate, zero-extended
- Draw_Color  out  32  colour, zero-extended
- Busy  out  1  command in progress
- Done  out  1  one-cycle pulse at command completion

## Operation
- States: IDLE, LOAD, DRAW, DONE. Reset (Reset_N=0) forces IDLE immediately; all outputs 0 except Cmd_Ready=1.
- IDLE: Cmd_Ready=1. On accept, latch all Cmd_* fields -> LOAD.
- LOAD (1 cycle): compute x_end = min(X+W, FB_WIDTH), y_end = min(Y+H, FB_HEIGHT) in 9-bit unsigned (no wrap). Empty if X>=FB_WIDTH, Y>=FB_HEIGHT, W==0 or H==0 -> DONE with zero writes; else x=X, y=Y -> DRAW.
- DRAW: row-major scan, x from X to x_end-1, y from Y to y_end-1. Each cycle with Hold=0 emits current (x,y) and advances; with Hold=0 at last pixel (x_end-1, y_end-1) -> DONE.
- Hold=1 in DRAW: counters frozen, Enable_Draw=0 next cycle, Draw_X/Y/Color keep last value. Hold ignored in other states.
- DONE (1 cycle): Done=1 -> IDLE.
- Busy=1 in LOAD, DRAW, DONE-entry cycle excluded (Busy=0 in DONE and IDLE).
- Cmd_* changes while not IDLE have no effect.

## Timing
- All outputs registered.
- Accept at edge 0 -> LOAD during cycle 1 -> first Enable_Draw=1 visible after edge 2.
- Fill of N clipped pixels with Hold=0: Enable_Draw high exactly N consecutive cycles; Done high the cycle after the last write; Cmd_Ready=1 the cycle after Done.
- Empty command: Done two cycles after accept, no Enable_Draw.
- Each Hold=1 cycle in DRAW adds exactly one cycle of latency.
- Reset_N low mid-DRAW: Enable_Draw drops asynchronously, no Done pulse, command discarded.

## Configuration
- RECT_FILL_OUTLINE_EN defined: Cmd_Outline=1 draws only the border of the clipped rectangle: first and last rows fully; interior rows emit x=X then jump to x=x_end-1 (single pixel if width 1). Write count 2*w+2*(h-2) for w,h>=2; equals fill count otherwise.
- Undefined: Cmd_Outline ignored, always full fill; outline logic absent.

## Test plan
- Fill X=10,Y=20,W=3,H=2,colour 0x1FF -> 6 writes (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), Draw_Color=0x1FF, first write 2 cycles after accept, Done 1 cycle after last.
- Clip X=158,Y=119,W=5,H=5 -> 2 writes (158,119),(159,119); no coordinate >=160/120.
- Empty W=0 or X=200 -> no Enable_Draw, Done 2 cycles after accept, Cmd_Ready back next cycle.
- Hold=1 for 3 cycles after 2nd pixel of 4x1 fill -> 4 writes, no duplicates, Done 3 cycles later than unheld run.
- Reset_N pulsed low during 160x120 clear -> Enable_Draw=0 immediately, Cmd_Ready=1, Busy=0, no Done; next command runs normally.
- With RECT_FILL_OUTLINE_EN, outline X=0,Y=0,W=4,H=3 -> 10 writes, (1,1),(2,1) never written; without macro same command -> 12 writes.

Source files
------------

// File: rtl/rect_fill_engine.sv
// ---------------------------------------------------------------------------
// rect_fill_engine
//
// Streams one framebuffer pixel write per clock for a rectangle command
// (origin, size, colour). The rectangle is clipped to the FB_WIDTH x
// FB_HEIGHT framebuffer and scanned row-major. The Enable_Draw, Draw_X,
// Draw_Y and Draw_Color outputs connect directly to the framebuffer write
// port.
//
// Optional feature: define RECT_FILL_OUTLINE_EN to honour Cmd_Outline.
// With the feature enabled, an outline command draws only the border of the
// clipped rectangle. Without it, every command is a full fill.
//
// Ports
//   Fast_Clock   in   clock shared with the framebuffer write port
//   Reset_N      in   asynchronous active-low reset
//   Cmd_Valid    in   command present
//   Cmd_Ready    out  engine idle; a command is taken on Cmd_Valid & Cmd_Ready
//   Cmd_X/Y      in   top-left corner of the rectangle (unsigned)
//   Cmd_W/H      in   width and height in pixels
//   Cmd_Color    in   fill colour
//   Cmd_Outline  in   draw the border only (RECT_FILL_OUTLINE_EN builds)
//   Hold         in   stall the pixel stream (the write port is shared)
//   Enable_Draw  out  pixel write strobe
//   Draw_X/Y     out  pixel coordinate, zero-extended to 32 bits
//   Draw_Color   out  pixel colour, zero-extended to 32 bits
//   Busy         out  command in progress
//   Done         out  one-cycle pulse when a command completes
//
// State table
//   state  | meaning
//   IDLE   | waiting for a command; Cmd_Ready high once settled
//   LOAD   | clip the latched command and detect empty rectangles
//   DRAW   | emit one pixel per cycle unless Hold is high
//   DONE   | completion; Done is raised on the following cycle
// ---------------------------------------------------------------------------
module rect_fill_engine #(
   parameter int FB_WIDTH   = 160,
   parameter int FB_HEIGHT  = 120,
   parameter int COLOR_BITS = 9
) (
   input  logic                  Fast_Clock,
   input  logic                  Reset_N,
   input  logic                  Cmd_Valid,
   output logic                  Cmd_Ready,
   input  logic [7:0]            Cmd_X,
   input  logic [6:0]            Cmd_Y,
   input  logic [7:0]            Cmd_W,
   input  logic [7:0]            Cmd_H,
   input  logic [COLOR_BITS-1:0] Cmd_Color,
   input  logic                  Cmd_Outline,
   input  logic                  Hold,
   output logic                  Enable_Draw,
   output logic [31:0]           Draw_X,
   output logic [31:0]           Draw_Y,
   output logic [31:0]           Draw_Color,
   output logic                  Busy,
   output logic                  Done
);

   localparam logic [8:0] FB_W9 = 9'(FB_WIDTH);
   localparam logic [8:0] FB_H9 = 9'(FB_HEIGHT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DRAW = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state_q, state_d;

   logic                  cmd_ready_q, cmd_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  enable_q, enable_d;
   logic [7:0]            draw_x_q, draw_x_d;
   logic [6:0]            draw_y_q, draw_y_d;
   logic [COLOR_BITS-1:0] draw_color_q, draw_color_d;

   // latched command
   logic [7:0]            x0_q, x0_d;
   logic [6:0]            y0_q, y0_d;
   logic [7:0]            w_q, w_d;
   logic [7:0]            h_q, h_d;
   logic [COLOR_BITS-1:0] color_q, color_d;

   // scan position and the last column/row of the clipped rectangle
   logic [7:0]            x_q, x_d;
   logic [6:0]            y_q, y_d;
   logic [7:0]            x_last_q, x_last_d;
   logic [6:0]            y_last_q, y_last_d;

`ifdef RECT_FILL_OUTLINE_EN
   logic                  outline_q, outline_d;
`else
   logic                  unused_outline;
   assign unused_outline = Cmd_Outline;
`endif

   logic       accept;
   logic [8:0] x_sum, y_sum;
   logic [8:0] x_end, y_end;
   logic       cmd_empty;
   logic       at_x_last, at_y_last;

   assign accept = Cmd_Valid & cmd_ready_q;

   // 9-bit sums so that a rectangle running past the edge cannot wrap
   assign x_sum     = {1'b0, x0_q} + {1'b0, w_q};
   assign y_sum     = {2'b00, y0_q} + {1'b0, h_q};
   assign x_end     = (x_sum > FB_W9) ? FB_W9 : x_sum;
   assign y_end     = (y_sum > FB_H9) ? FB_H9 : y_sum;
   assign cmd_empty = ({1'b0, x0_q} >= FB_W9) || ({2'b00, y0_q} >= FB_H9) ||
                      (w_q == 8'd0) || (h_q == 8'd0);

   assign at_x_last = (x_q == x_last_q);
   assign at_y_last = (y_q == y_last_q);

   always_comb begin
      state_d      = state_q;
      cmd_ready_d  = 1'b0;
      done_d       = (state_q == S_DONE);
      enable_d     = 1'b0;
      draw_x_d     = draw_x_q;
      draw_y_d     = draw_y_q;
      draw_color_d = draw_color_q;
      x0_d         = x0_q;
      y0_d         = y0_q;
      w_d          = w_q;
      h_d          = h_q;
      color_d      = color_q;
      x_d          = x_q;
      y_d          = y_q;
      x_last_d     = x_last_q;
      y_last_d     = y_last_q;
`ifdef RECT_FILL_OUTLINE_EN
      outline_d    = outline_q;
`endif

      unique case (state_q)
         S_IDLE: begin
            // Ready rises one cycle after entering IDLE and falls on the
            // accepting edge, so a held Cmd_Valid is taken only once.
            cmd_ready_d = ~accept;
            if (accept) begin
               x0_d      = Cmd_X;
               y0_d      = Cmd_Y;
               w_d       = Cmd_W;
               h_d       = Cmd_H;
               color_d   = Cmd_Color;
`ifdef RECT_FILL_OUTLINE_EN
               outline_d = Cmd_Outline;
`endif
               state_d   = S_LOAD;
            end
         end

         S_LOAD: begin
            x_last_d = 8'(x_end - 9'd1);
            y_last_d = 7'(y_end - 9'd1);
            x_d      = x0_q;
            y_d      = y0_q;
            state_d  = cmd_empty ? S_DONE : S_DRAW;
         end

         S_DRAW: begin
            if (!Hold) begin
               enable_d     = 1'b1;
               draw_x_d     = x_q;
               draw_y_d     = y_q;
               draw_color_d = color_q;
               if (at_x_last && at_y_last) begin
                  state_d = S_DONE;
               end else if (at_x_last) begin
                  x_d = x0_q;
                  y_d = y_q + 7'd1;
               end else begin
                  x_d = x_q + 8'd1;
`ifdef RECT_FILL_OUTLINE_EN
                  // interior rows of an outline: left edge, then right edge
                  if (outline_q && (x_q == x0_q) && (y_q != y0_q) && !at_y_last)
                     x_d = x_last_q;
`endif
               end
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Busy spans accept through the last write, so that at any cycle exactly
      // one of Cmd_Ready, Busy or Done is high.
      busy_d = (state_d == S_LOAD) || (state_d == S_DRAW) ||
               (state_q == S_LOAD) || (state_q == S_DRAW);
   end

   always_ff @(posedge Fast_Clock or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q      <= S_IDLE;
         cmd_ready_q  <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         enable_q     <= 1'b0;
         draw_x_q     <= '0;
         draw_y_q     <= '0;
         draw_color_q <= '0;
         x0_q         <= '0;
         y0_q         <= '0;
         w_q          <= '0;
         h_q          <= '0;
         color_q      <= '0;
         x_q          <= '0;
         y_q          <= '0;
         x_last_q     <= '0;
         y_last_q     <= '0;
`ifdef RECT_FILL_OUTLINE_EN
         outline_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         cmd_ready_q  <= cmd_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         enable_q     <= enable_d;
         draw_x_q     <= draw_x_d;
         draw_y_q     <= draw_y_d;
         draw_color_q <= draw_color_d;
         x0_q         <= x0_d;
         y0_q         <= y0_d;
         w_q          <= w_d;
         h_q          <= h_d;
         color_q      <= color_d;
         x_q          <= x_d;
         y_q          <= y_d;
         x_last_q     <= x_last_d;
         y_last_q     <= y_last_d;
`ifdef RECT_FILL_OUTLINE_EN
         outline_q    <= outline_d;
`endif
      end
   end

   assign Cmd_Ready   = cmd_ready_q;
   assign Busy        = busy_q;
   assign Done        = done_q;
   assign Enable_Draw = enable_q;
   assign Draw_X      = {24'd0, draw_x_q};
   assign Draw_Y      = {25'd0, draw_y_q};
   assign Draw_Color  = {{(32-COLOR_BITS){1'b0}}, draw_color_q};

endmodule

// File: tb/tb_rect_fill_engine.sv
// ---------------------------------------------------------------------------
// tb_rect_fill_engine
//
// Scoreboard bench for rect_fill_engine. Each issued command pushes its
// expected pixel list, plus a completion record, into queues. The pixel list
// is computed from the clipped rectangle by plain loops. A monitor process
// pops these records and compares them against every pixel write and every
// Done pulse.
// ---------------------------------------------------------------------------
module tb_rect_fill_engine;

   localparam int FBW = 160;
   localparam int FBH = 120;
`ifdef RECT_FILL_OUTLINE_EN
   localparam bit OUTLINE_ON = 1'b1;
`else
   localparam bit OUTLINE_ON = 1'b0;
`endif

   logic        Fast_Clock = 1'b0;
   logic        Reset_N;
   logic        Cmd_Valid = 1'b0;
   logic        Cmd_Ready;
   logic [7:0]  Cmd_X = '0;
   logic [6:0]  Cmd_Y = '0;
   logic [7:0]  Cmd_W = '0;
   logic [7:0]  Cmd_H = '0;
   logic [8:0]  Cmd_Color = '0;
   logic        Cmd_Outline = 1'b0;
   logic        Hold = 1'b0;
   logic        Enable_Draw;
   logic [31:0] Draw_X, Draw_Y, Draw_Color;
   logic        Busy, Done;

   rect_fill_engine dut (
      .Fast_Clock (Fast_Clock),
      .Reset_N    (Reset_N),
      .Cmd_Valid  (Cmd_Valid),
      .Cmd_Ready  (Cmd_Ready),
      .Cmd_X      (Cmd_X),
      .Cmd_Y      (Cmd_Y),
      .Cmd_W      (Cmd_W),
      .Cmd_H      (Cmd_H),
      .Cmd_Color  (Cmd_Color),
      .Cmd_Outline(Cmd_Outline),
      .Hold       (Hold),
      .Enable_Draw(Enable_Draw),
      .Draw_X     (Draw_X),
      .Draw_Y     (Draw_Y),
      .Draw_Color (Draw_Color),
      .Busy       (Busy),
      .Done       (Done)
   );

   always #5 Fast_Clock = ~Fast_Clock;

   int cyc = 0;
   always @(posedge Fast_Clock) cyc <= cyc + 1;

   typedef struct {
      int x;
      int y;
      int c;
   } pix_t;

   typedef struct {
      int n;
      int acc;
      bit timed;
      int extra;
   } cmd_t;

   pix_t exp_pix[$];
   cmd_t exp_cmd[$];
   pix_t mp;
   cmd_t mc;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int sent = 0;
   int cur_n = 0;
   int first_en = -1;
   bit prev_done = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Reference model: every pixel of the clipped rectangle in row-major
   // order. In outline mode only pixels on the rectangle border are kept.
   task automatic model(input int x, input int y, input int w, input int h,
                        input int c, input bit outl, output int n);
      int xe, ye;
      pix_t p;
      xe = (x + w < FBW) ? x + w : FBW;
      ye = (y + h < FBH) ? y + h : FBH;
      n = 0;
      for (int yy = y; yy < ye; yy++) begin
         for (int xx = x; xx < xe; xx++) begin
            if (!(outl && OUTLINE_ON) || yy == y || yy == ye - 1 || xx == x || xx == xe - 1) begin
               p.x = xx;
               p.y = yy;
               p.c = c;
               exp_pix.push_back(p);
               n++;
            end
         end
      end
   endtask

   // monitor / scoreboard
   always @(negedge Fast_Clock) begin
      if (!Reset_N) begin
         prev_done = 1'b0;
      end else begin
         if (prev_done) chk("ready_after_done", Cmd_Ready, 1);
         prev_done = Done;
         if (Enable_Draw) begin
            chk("busy_while_draw", Busy, 1);
            if (exp_pix.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_write actual=(%0d,%0d) expected=no write", Draw_X, Draw_Y);
            end else begin
               mp = exp_pix.pop_front();
               chk("draw_x", Draw_X, mp.x);
               chk("draw_y", Draw_Y, mp.y);
               chk("draw_color", Draw_Color, mp.c);
            end
            if (first_en < 0) first_en = cyc;
            cur_n++;
         end
         if (Done) begin
            chk("busy_at_done", Busy, 0);
            chk("ready_at_done", Cmd_Ready, 0);
            if (exp_cmd.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=1 expected=0 (cycle %0d)", cyc);
            end else begin
               mc = exp_cmd.pop_front();
               chk("write_count", cur_n, mc.n);
               if (mc.timed) begin
                  chk("done_latency", cyc - mc.acc, mc.n + 2 + mc.extra);
                  if (mc.n > 0) chk("first_write_latency", first_en - mc.acc, 2);
               end
            end
            cur_n = 0;
            first_en = -1;
            done_cnt++;
         end
      end
   end

   task automatic send(input int x, input int y, input int w, input int h, input int c,
                       input bit outl, input bit timed, input int extra);
      int g;
      int n;
      cmd_t e;
      g = 0;
      @(negedge Fast_Clock);
      while (Cmd_Ready !== 1'b1 && g < 1000) begin
         @(negedge Fast_Clock);
         g++;
      end
      if (Cmd_Ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual=%0d expected=1", Cmd_Ready);
         return;
      end
      Cmd_X       = 8'(x);
      Cmd_Y       = 7'(y);
      Cmd_W       = 8'(w);
      Cmd_H       = 8'(h);
      Cmd_Color   = 9'(c);
      Cmd_Outline = outl;
      Cmd_Valid   = 1'b1;
      model(x & 255, y & 127, w & 255, h & 255, c & 511, outl, n);
      e.n = n;
      e.acc = cyc + 1;
      e.timed = timed;
      e.extra = extra;
      exp_cmd.push_back(e);
      sent++;
      @(negedge Fast_Clock);
      // fields change after accept; the engine must ignore them
      Cmd_Valid   = 1'b0;
      Cmd_X       = 8'($urandom);
      Cmd_Y       = 7'($urandom);
      Cmd_W       = 8'($urandom);
      Cmd_H       = 8'($urandom);
      Cmd_Color   = 9'($urandom);
      Cmd_Outline = 1'($urandom);
   endtask

   task automatic wait_done(input int target, input bit rand_hold);
      int g;
      g = 0;
      while (done_cnt < target && g < 30000) begin
         @(negedge Fast_Clock);
         #1;
         Hold = rand_hold ? ($urandom_range(0, 3) == 0) : 1'b0;
         g++;
      end
      Hold = 1'b0;
      if (done_cnt < target) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=%0d expected=%0d", done_cnt, target);
      end
   endtask

   initial begin
      int seen, g, snap, x, y, w, h;
      bit rh;
      Reset_N = 1'b0;
      repeat (3) @(negedge Fast_Clock);
      chk("reset_ready", Cmd_Ready, 1);
      chk("reset_busy", Busy, 0);
      chk("reset_done", Done, 0);
      chk("reset_enable", Enable_Draw, 0);
      chk("reset_draw_x", Draw_X, 0);
      chk("reset_draw_color", Draw_Color, 0);
      Reset_N = 1'b1;

      // basic fill
      send(10, 20, 3, 2, 9'h1FF, 1'b0, 1'b1, 0);
      wait_done(sent, 1'b0);
      // clip at bottom-right corner
      send(158, 119, 5, 5, 9'h0A5, 1'b0, 1'b1, 0);
      wait_done(sent, 1'b0);
      // empty commands
      send(5, 5, 0, 4, 9'h011, 1'b0, 1'b1, 0);
      wait_done(sent, 1'b0);
      send(200, 5, 4, 4, 9'h022, 1'b0, 1'b1, 0);
      wait_done(sent, 1'b0);
      send(5, 125, 4, 4, 9'h033, 1'b0, 1'b1, 0);
      wait_done(sent, 1'b0);
      send(5, 5, 4, 0, 9'h044, 1'b0, 1'b1, 0);
      wait_done(sent, 1'b0);
      // outline: 10 writes with the feature, 12 without
      send(0, 0, 4, 3, 9'h155, 1'b1, 1'b1, 0);
      wait_done(sent, 1'b0);
      send(3, 3, 1, 5, 9'h0F0, 1'b1, 1'b1, 0);
      wait_done(sent, 1'b0);

      // Hold for three cycles after the second pixel of a 4x1 fill
      send(10, 5, 4, 1, 9'h0AA, 1'b0, 1'b1, 3);
      seen = 0;
      g = 0;
      while (seen < 2 && g < 100) begin
         @(negedge Fast_Clock);
         if (Enable_Draw) seen++;
         g++;
      end
      Hold = 1'b1;
      repeat (3) begin
         @(negedge Fast_Clock);
         #1;
         chk("hold_no_write", Enable_Draw, 0);
         chk("hold_x_kept", Draw_X, 11);
      end
      Hold = 1'b0;
      wait_done(sent, 1'b0);

      // reset in the middle of a full-screen clear
      send(0, 0, 160, 120, 9'h1C3, 1'b0, 1'b0, 0);
      seen = 0;
      g = 0;
      while (seen < 50 && g < 1000) begin
         @(negedge Fast_Clock);
         if (Enable_Draw) seen++;
         g++;
      end
      #2;
      Reset_N = 1'b0;
      exp_pix.delete();
      exp_cmd.delete();
      cur_n = 0;
      first_en = -1;
      sent--;
      #1;
      chk("abort_enable", Enable_Draw, 0);
      chk("abort_ready", Cmd_Ready, 1);
      chk("abort_busy", Busy, 0);
      chk("abort_done", Done, 0);
      snap = done_cnt;
      repeat (2) @(negedge Fast_Clock);
      Reset_N = 1'b1;
      repeat (5) @(negedge Fast_Clock);
      chk("no_done_after_abort", done_cnt, snap);
      send(20, 30, 5, 3, 9'h07E, 1'b0, 1'b1, 0);
      wait_done(sent, 1'b0);

      // full-screen clear with oversized request
      send(0, 0, 255, 255, 9'h101, 1'b0, 1'b1, 0);
      wait_done(sent, 1'b0);

      // randomized commands, odd iterations with random Hold
      for (int i = 0; i < 60; i++) begin
         x = ($urandom_range(0, 3) == 0) ? $urandom_range(140, 255) : $urandom_range(0, 159);
         y = ($urandom_range(0, 3) == 0) ? $urandom_range(100, 127) : $urandom_range(0, 119);
         w = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 16);
         h = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 12);
         if (w > 40) h = $urandom_range(0, 6);
         rh = (i % 2) == 1;
         send(x, y, w, h, $urandom_range(0, 511), 1'($urandom_range(0, 1)), !rh, 0);
         wait_done(sent, rh);
      end

      repeat (5) @(negedge Fast_Clock);
      chk("leftover_pixels", exp_pix.size(), 0);
      chk("leftover_cmds", exp_cmd.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
